// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the five-stage core: PC register, ID->EX->MEM->WB valid/rd/flag chain,
// load-use stall, redirect flush and EX forwarding selects. Optional counters: PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned     RA_W     = 5,
   parameter int unsigned     CNT_W    = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [RA_W-1:0] id_rs1,
   input  logic [RA_W-1:0] id_rs2,
   input  logic            id_use_rs1,
   input  logic            id_use_rs2,
   input  logic [RA_W-1:0] id_rd,
   input  logic            id_regwrite,
   input  logic            id_memread,
   input  logic            ex_redirect,
   input  logic [XLEN-1:0] ex_target,
   input  logic            ext_stall,
   output logic [XLEN-1:0] pc,
   output logic            id_valid,
   output logic            ex_valid,
   output logic            mem_valid,
   output logic            wb_valid,
   output logic            stall_fd,
   output logic            bubble_ex,
   output logic            flush_id,
   output logic [1:0]      fwd_a,
   output logic [1:0]      fwd_b,
   output logic [RA_W-1:0] wb_rd,
   output logic            wb_regwrite
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [CNT_W-1:0] ret_cnt,
   output logic [CNT_W-1:0] stall_cnt
`endif
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic            id_valid_q, id_valid_d;
   logic            ex_valid_q, ex_valid_d, ex_regwrite_q, ex_regwrite_d;
   logic            ex_memread_q, ex_memread_d;
   logic [RA_W-1:0] ex_rd_q, ex_rd_d, ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
   logic            mem_valid_q, mem_valid_d, mem_regwrite_q, mem_regwrite_d;
   logic [RA_W-1:0] mem_rd_q, mem_rd_d;
   logic            wb_valid_q, wb_valid_d, wb_regwrite_q, wb_regwrite_d;
   logic [RA_W-1:0] wb_rd_q, wb_rd_d;
   logic            load_use, redirect;

   assign load_use = id_valid_q & ex_valid_q & ex_memread_q & (ex_rd_q != '0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd_q)) | (id_use_rs2 & (id_rs2 == ex_rd_q)));
   assign redirect = ex_valid_q & ex_redirect;

   always_comb begin
      pc_d           = pc_q;
      id_valid_d     = id_valid_q;
      ex_valid_d     = ex_valid_q;
      ex_rd_d        = ex_rd_q;
      ex_regwrite_d  = ex_regwrite_q;
      ex_memread_d   = ex_memread_q;
      ex_rs1_d       = ex_rs1_q;
      ex_rs2_d       = ex_rs2_q;
      mem_valid_d    = mem_valid_q;
      mem_rd_d       = mem_rd_q;
      mem_regwrite_d = mem_regwrite_q;
      wb_valid_d     = wb_valid_q;
      wb_rd_d        = wb_rd_q;
      wb_regwrite_d  = wb_regwrite_q;
      if (!ext_stall) begin
         // MEM and WB always advance unless the whole pipe is frozen
         mem_valid_d    = ex_valid_q;
         mem_rd_d       = ex_rd_q;
         mem_regwrite_d = ex_regwrite_q;
         wb_valid_d     = mem_valid_q;
         wb_rd_d        = mem_rd_q;
         wb_regwrite_d  = mem_regwrite_q;
         if (redirect) begin
            pc_d       = ex_target;
            id_valid_d = 1'b0;
            ex_valid_d = 1'b0;
         end else if (load_use) begin
            ex_valid_d = 1'b0;
         end else begin
            pc_d          = pc_q + XLEN'(4);
            id_valid_d    = 1'b1;
            ex_valid_d    = id_valid_q;
            ex_rd_d       = id_rd;
            ex_regwrite_d = id_regwrite;
            ex_memread_d  = id_memread;
            ex_rs1_d      = id_rs1;
            ex_rs2_d      = id_rs2;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q           <= RESET_PC;
         id_valid_q     <= 1'b0;
         ex_valid_q     <= 1'b0;
         ex_rd_q        <= '0;
         ex_regwrite_q  <= 1'b0;
         ex_memread_q   <= 1'b0;
         ex_rs1_q       <= '0;
         ex_rs2_q       <= '0;
         mem_valid_q    <= 1'b0;
         mem_rd_q       <= '0;
         mem_regwrite_q <= 1'b0;
         wb_valid_q     <= 1'b0;
         wb_rd_q        <= '0;
         wb_regwrite_q  <= 1'b0;
      end else begin
         pc_q           <= pc_d;
         id_valid_q     <= id_valid_d;
         ex_valid_q     <= ex_valid_d;
         ex_rd_q        <= ex_rd_d;
         ex_regwrite_q  <= ex_regwrite_d;
         ex_memread_q   <= ex_memread_d;
         ex_rs1_q       <= ex_rs1_d;
         ex_rs2_q       <= ex_rs2_d;
         mem_valid_q    <= mem_valid_d;
         mem_rd_q       <= mem_rd_d;
         mem_regwrite_q <= mem_regwrite_d;
         wb_valid_q     <= wb_valid_d;
         wb_rd_q        <= wb_rd_d;
         wb_regwrite_q  <= wb_regwrite_d;
      end
   end

   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (mem_valid_q & mem_regwrite_q & (mem_rd_q != '0) & (mem_rd_q == ex_rs1_q)) fwd_a = 2'b01;
      else if (wb_valid_q & wb_regwrite_q & (wb_rd_q != '0) & (wb_rd_q == ex_rs1_q)) fwd_a = 2'b10;
      if (mem_valid_q & mem_regwrite_q & (mem_rd_q != '0) & (mem_rd_q == ex_rs2_q)) fwd_b = 2'b01;
      else if (wb_valid_q & wb_regwrite_q & (wb_rd_q != '0) & (wb_rd_q == ex_rs2_q)) fwd_b = 2'b10;
   end

   // Gated by reset so every control output reads 0 while held in reset
   assign stall_fd    = reset & (ext_stall | (load_use & ~redirect));
   assign bubble_ex   = reset & ~ext_stall & (redirect | load_use);
   assign flush_id    = reset & ~ext_stall & redirect;
   assign pc          = pc_q;
   assign id_valid    = id_valid_q;
   assign ex_valid    = ex_valid_q;
   assign mem_valid   = mem_valid_q;
   assign wb_valid    = wb_valid_q;
   assign wb_rd       = wb_rd_q;
   assign wb_regwrite = wb_valid_q & wb_regwrite_q;

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] cyc_q, ret_q, stl_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cyc_q <= '0;
         ret_q <= '0;
         stl_q <= '0;
      end else begin
         cyc_q <= cyc_q + CNT_W'(1);
         if (wb_valid_q & ~ext_stall) ret_q <= ret_q + CNT_W'(1);
         if (load_use | ext_stall) stl_q <= stl_q + CNT_W'(1);
      end
   end

   assign cyc_cnt   = cyc_q;
   assign ret_cnt   = ret_q;
   assign stall_cnt = stl_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; counter checks run when PIPE_PERF_CNT_EN is set.
module tb_pipe_hazard_ctrl;

   logic        clk, reset;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_use_rs1, id_use_rs2, id_regwrite, id_memread;
   logic        ex_redirect, ext_stall;
   logic [31:0] ex_target, pc;
   logic        id_valid, ex_valid, mem_valid, wb_valid;
   logic        stall_fd, bubble_ex, flush_id, wb_regwrite;
   logic [1:0]  fwd_a, fwd_b;
   logic [4:0]  wb_rd;
`ifdef PIPE_PERF_CNT_EN
   logic [31:0] cyc_cnt, ret_cnt, stall_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   pipe_hazard_ctrl dut (
      .clk(clk), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
      .ex_redirect(ex_redirect), .ex_target(ex_target), .ext_stall(ext_stall),
      .pc(pc), .id_valid(id_valid), .ex_valid(ex_valid), .mem_valid(mem_valid),
      .wb_valid(wb_valid), .stall_fd(stall_fd), .bubble_ex(bubble_ex), .flush_id(flush_id),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite)
`ifdef PIPE_PERF_CNT_EN
      , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .stall_cnt(stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running, need done");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_id(input logic [4:0] rd, input logic rw, input logic mr,
                         input logic u1, input logic [4:0] r1, input logic u2,
                         input logic [4:0] r2);
      id_rd = rd; id_regwrite = rw; id_memread = mr;
      id_use_rs1 = u1; id_rs1 = r1; id_use_rs2 = u2; id_rs2 = r2;
   endtask

   task automatic do_rst();
      set_id(5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
      ex_redirect = 1'b0; ex_target = '0; ext_stall = 1'b0;
      reset = 1'b0;
      #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      set_id(5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
      ex_redirect = 1'b0; ex_target = '0; ext_stall = 1'b0;
      reset = 1'b0;
      tick(); tick();
      n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h need 0", pc); end
      n_cmp++; if ({id_valid, ex_valid, mem_valid, wb_valid} !== 4'b0) begin
         n_bad++; $display("FAIL reset_valid: got %b need 0000",
                           {id_valid, ex_valid, mem_valid, wb_valid}); end
      n_cmp++; if ({stall_fd, bubble_ex, flush_id, fwd_a, fwd_b, wb_rd, wb_regwrite} !== '0) begin
         n_bad++; $display("FAIL reset_outs: got %b need 0",
                           {stall_fd, bubble_ex, flush_id, fwd_a, fwd_b, wb_rd, wb_regwrite}); end
      reset = 1'b1;
   endtask

   task automatic test_normal();
      do_rst();
      set_id(5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
      for (int k = 0; k < 6; k++) begin
         if (k > 0) tick();
         #1;
         n_cmp++; if (pc !== 32'(4 * k)) begin
            n_bad++; $display("FAIL normal_pc[%0d]: got %h need %h", k, pc, 32'(4 * k)); end
         n_cmp++; if ({id_valid, ex_valid, mem_valid, wb_valid} !==
                      {k >= 1, k >= 2, k >= 3, k >= 4}) begin
            n_bad++; $display("FAIL normal_valid[%0d]: got %b need %b", k,
                              {id_valid, ex_valid, mem_valid, wb_valid},
                              {k >= 1, k >= 2, k >= 3, k >= 4}); end
      end
      n_cmp++; if (wb_rd !== 5'd7 || wb_regwrite !== 1'b1) begin
         n_bad++; $display("FAIL normal_wb: got rd=%0d we=%b need rd=7 we=1", wb_rd, wb_regwrite); end
      n_cmp++; if (stall_fd !== 1'b0 || bubble_ex !== 1'b0 || flush_id !== 1'b0) begin
         n_bad++; $display("FAIL normal_ctrl: got %b%b%b need 000", stall_fd, bubble_ex, flush_id); end
   endtask

   task automatic test_load_use();
      do_rst();
      set_id(5'd5, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0);  // lw x5
      tick(); tick();
      set_id(5'd6, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 5'd1);  // add x6,x5,x1
      #1;
      n_cmp++; if ({stall_fd, bubble_ex, flush_id} !== 3'b110) begin
         n_bad++; $display("FAIL lu_ctrl: got %b need 110", {stall_fd, bubble_ex, flush_id}); end
      n_cmp++; if (pc !== 32'h8) begin n_bad++; $display("FAIL lu_pc0: got %h need 8", pc); end
      tick(); #1;
      n_cmp++; if (pc !== 32'h8) begin n_bad++; $display("FAIL lu_pc_hold: got %h need 8", pc); end
      n_cmp++; if ({stall_fd, bubble_ex, ex_valid, mem_valid} !== 4'b0001) begin
         n_bad++; $display("FAIL lu_bubble: got %b need 0001",
                           {stall_fd, bubble_ex, ex_valid, mem_valid}); end
      tick(); #1;
      n_cmp++; if (pc !== 32'hC) begin n_bad++; $display("FAIL lu_pc_go: got %h need c", pc); end
      n_cmp++; if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
         n_bad++; $display("FAIL lu_fwd: got a=%b b=%b need a=10 b=00", fwd_a, fwd_b); end
      n_cmp++; if (wb_rd !== 5'd5 || wb_regwrite !== 1'b1 || ex_valid !== 1'b1) begin
         n_bad++; $display("FAIL lu_wb: got rd=%0d we=%b exv=%b need 5 1 1",
                           wb_rd, wb_regwrite, ex_valid); end
   endtask

   task automatic test_forward();
      do_rst();
      set_id(5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);  // add x3 twice
      tick(); tick(); tick();
      set_id(5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 5'd3);  // rs1=x0, rs2=x3, rd=x0
      tick();
      set_id(5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 5'd0);  // rs1=x3, rs2=x0
      #1;
      n_cmp++; if (fwd_b !== 2'b01) begin
         n_bad++; $display("FAIL fwd_mem_prio: got %b need 01", fwd_b); end
      n_cmp++; if (fwd_a !== 2'b00) begin
         n_bad++; $display("FAIL fwd_x0_a: got %b need 00", fwd_a); end
      tick(); #1;
      // MEM now holds a rd=x0 writer and EX reads x0 on rs2
      n_cmp++; if (fwd_a !== 2'b10) begin
         n_bad++; $display("FAIL fwd_wb_a: got %b need 10", fwd_a); end
      n_cmp++; if (fwd_b !== 2'b00) begin
         n_bad++; $display("FAIL fwd_rd0_b: got %b need 00", fwd_b); end
   endtask

   task automatic test_redirect();
      do_rst();
      set_id(5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
      tick(); tick();
      ex_redirect = 1'b1; ex_target = 32'h100;
      #1;
      n_cmp++; if ({stall_fd, bubble_ex, flush_id} !== 3'b011) begin
         n_bad++; $display("FAIL br_ctrl: got %b need 011", {stall_fd, bubble_ex, flush_id}); end
      tick();
      ex_redirect = 1'b0;
      #1;
      n_cmp++; if (pc !== 32'h100) begin n_bad++; $display("FAIL br_pc: got %h need 100", pc); end
      n_cmp++; if ({id_valid, ex_valid, mem_valid} !== 3'b001) begin
         n_bad++; $display("FAIL br_valid: got %b need 001", {id_valid, ex_valid, mem_valid}); end
      do_rst();
      set_id(5'd5, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0);
      tick(); tick();
      set_id(5'd6, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0);
      ex_redirect = 1'b1; ex_target = 32'h200;
      #1;
      n_cmp++; if ({stall_fd, bubble_ex, flush_id} !== 3'b011) begin
         n_bad++; $display("FAIL br_lu_ctrl: got %b need 011", {stall_fd, bubble_ex, flush_id}); end
      tick();
      ex_redirect = 1'b0;
      #1;
      n_cmp++; if (pc !== 32'h200 || id_valid !== 1'b0 || ex_valid !== 1'b0) begin
         n_bad++; $display("FAIL br_lu_state: got pc=%h idv=%b exv=%b need 200 0 0",
                           pc, id_valid, ex_valid); end
   endtask

   task automatic test_ext_stall();
      do_rst();
      set_id(5'd5, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0);
      tick(); tick();
      set_id(5'd6, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0);
      ext_stall = 1'b1;
      #1;
      n_cmp++; if ({stall_fd, bubble_ex, flush_id} !== 3'b100) begin
         n_bad++; $display("FAIL xs_ctrl: got %b need 100", {stall_fd, bubble_ex, flush_id}); end
      for (int k = 0; k < 3; k++) begin
         tick(); #1;
         n_cmp++; if (pc !== 32'h8 || {id_valid, ex_valid, mem_valid} !== 3'b110) begin
            n_bad++; $display("FAIL xs_freeze[%0d]: got pc=%h v=%b need 8 110", k, pc,
                              {id_valid, ex_valid, mem_valid}); end
      end
      ext_stall = 1'b0;
      #1;
      n_cmp++; if ({stall_fd, bubble_ex} !== 2'b11) begin
         n_bad++; $display("FAIL xs_release: got %b need 11", {stall_fd, bubble_ex}); end
      tick(); #1;
      n_cmp++; if (pc !== 32'h8 || {ex_valid, mem_valid, stall_fd} !== 3'b010) begin
         n_bad++; $display("FAIL xs_bubble: got pc=%h v=%b need 8 010", pc,
                           {ex_valid, mem_valid, stall_fd}); end
      tick(); #1;
      n_cmp++; if (pc !== 32'hC || ex_valid !== 1'b1) begin
         n_bad++; $display("FAIL xs_resume: got pc=%h exv=%b need c 1", pc, ex_valid); end
      ext_stall = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      n_cmp++; if (pc !== 32'h0 || {id_valid, ex_valid, mem_valid, wb_valid} !== 4'b0 ||
                   stall_fd !== 1'b0) begin
         n_bad++; $display("FAIL xs_async_rst: got pc=%h v=%b st=%b need 0 0000 0", pc,
                           {id_valid, ex_valid, mem_valid, wb_valid}, stall_fd); end
      ext_stall = 1'b0;
      reset = 1'b1;
   endtask

`ifdef PIPE_PERF_CNT_EN
   task automatic test_perf();
      do_rst();
      set_id(5'd5, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0);
      tick(); tick();
      set_id(5'd6, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0);
      for (int k = 0; k < 8; k++) tick();
      #1;
      n_cmp++; if (cyc_cnt !== 32'd10) begin
         n_bad++; $display("FAIL perf_cyc: got %0d need 10", cyc_cnt); end
      n_cmp++; if (stall_cnt !== 32'd1) begin
         n_bad++; $display("FAIL perf_stall: got %0d need 1", stall_cnt); end
      n_cmp++; if (ret_cnt !== 32'd5) begin
         n_bad++; $display("FAIL perf_ret: got %0d need 5", ret_cnt); end
   endtask
`endif

   initial begin
      test_reset();
      test_normal();
      test_load_use();
      test_forward();
      test_redirect();
      test_ext_stall();
`ifdef PIPE_PERF_CNT_EN
      test_perf();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised pipeline control for the five-stage RISC-V core: owns the PC register and the per-stage valid/rd/control shift chain ID->EX->MEM->WB. Generates load-use stalls, branch/jump flushes and EX-operand forwarding selects. Replaces the single-cycle PC/npc path when moving the core to the pipelined datapath; the datapath muxes and pipeline data registers consume its outputs.

Parameters:
XLEN, 32, width of PC and redirect target
RESET_PC, 32'h0000_0000, PC value held during and after reset
RA_W, 5, register-address width
CNT_W, 32, width of performance counters (used only with PIPE_PERF_CNT_EN)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
id_rs1  in  RA_W  source reg 1 of instruction in ID
id_rs2  in  RA_W  source reg 2 of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
id_rd  in  RA_W  destination of ID instruction
id_regwrite  in  1  ID instruction writes rd
id_memread  in  1  ID instruction is a load
ex_redirect  in  1  EX resolved taken branch/jump
ex_target  in  XLEN  redirect target
ext_stall  in  1  memory not ready, freezes whole pipeline
pc  out  XLEN  fetch address
id_valid, ex_valid, mem_valid, wb_valid  out  1 each  stage holds a real instruction
stall_fd  out  1  hold PC and IF/ID register
bubble_ex  out  1  insert NOP into ID/EX
flush_id  out  1  kill IF/ID contents
fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 01 MEM ALU result, 10 WB write data
wb_rd  out  RA_W  regfile write address
wb_regwrite  out  1  regfile write enable (gated by wb_valid)

Behaviour:
- Reset (reset=0, async): pc=RESET_PC; all valid bits, rd fields, regwrite/memread flags cleared; all outputs 0 except pc.
- load_use = id_valid & ex_valid & ex_memread & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- redirect = ex_valid & ex_redirect.
- Priority per cycle: ext_stall > redirect > load_use > normal.
- ext_stall=1: every register holds (pc, all valid/rd/flags); stall_fd=1, bubble_ex=0, flush_id=0. A pending redirect/load_use is re-evaluated when ext_stall drops.
- redirect: pc<=ex_target; id_valid<=0; ex_valid<=0; EX contents advance to MEM normally; flush_id=1, bubble_ex=1, stall_fd=0.
- load_use (no redirect): pc and ID hold; ex_valid<=0 (bubble); MEM/WB advance; stall_fd=1, bubble_ex=1. Exactly one bubble per load-use pair.
- normal: pc<=pc+4 (mod 2^XLEN, wraps silently); id_valid<=1; each stage copies the previous stage's valid/rd/regwrite/memread/rs1/rs2.
- First instruction reaches ID one cycle after reset release; reaches WB 3 cycles later absent stalls.
- Forwarding (combinational from EX regs): fwd_a=01 if mem_valid & mem_regwrite & mem_rd!=0 & mem_rd==ex_rs1; else 10 if same test on WB; else 00. fwd_b same with ex_rs2. MEM has priority over WB. Loads in MEM never match EX (guaranteed by load_use).
- rd==0 never forwards and never stalls.
- wb_regwrite = wb_valid & wb_regwrite_reg.
- Reset asserted mid-stall or mid-redirect: immediate return to reset state; no pending state survives.

Optional Feature:
PIPE_PERF_CNT_EN: adds outputs cyc_cnt, ret_cnt, stall_cnt (CNT_W each, reset 0, wrap on overflow). cyc_cnt increments every cycle out of reset; ret_cnt increments when wb_valid=1 and ext_stall=0; stall_cnt increments on cycles with load_use or ext_stall asserted. Without the macro the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset release, no hazards, 6 cycles -> pc = 0,4,8,12,16,20; id_valid rises at cycle 1, wb_valid at cycle 4.
- lw x5 in EX, ID add x6,x5,x1 (id_use_rs1=1, id_rs1=5) -> stall_fd=1, bubble_ex=1 for exactly 1 cycle, pc held; next cycle fwd_a=10 for the add.
- add x3 in MEM and x3 in WB, EX reads rs2=3 -> fwd_b=01; MEM rd=0 with EX rs1=0 -> fwd_a=00.
- ex_redirect=1, ex_target=0x100 -> next pc=0x100, id_valid=0, ex_valid=0, flush_id=1 that cycle; redirect coinciding with load_use -> redirect wins, no stall.
- ext_stall held 3 cycles during a load-use hazard -> all state frozen, one bubble inserted after release; async reset mid-stall -> pc=RESET_PC immediately, all valid=0.
- PIPE_PERF_CNT_EN defined, 10 cycles with 1 load-use stall -> cyc_cnt=10, stall_cnt=1, ret_cnt = count of wb_valid cycles.
